// File: rtl/mpu_ctx_stack.sv
// Preemption-context LIFO for the MPU: tracks nested handler frames and drives the active context.
// Optional fault capture is compiled in with `define MPU_CTX_FAULT_LATCH_EN.
module mpu_ctx_stack #(
  parameter int                DEPTH   = 8,
  parameter int                PRIO_W  = 8,
  parameter int                ID_W    = 4,
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] BASE_EP = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       take,
  input  logic                       ret,
  input  logic [PRIO_W-1:0]          irq_prio,
  input  logic [ID_W-1:0]            irq_id,
  input  logic [ADDR_W-1:0]          sp,
  output logic                       ready,
  output logic [PRIO_W-1:0]          cur_prio,
  output logic [ID_W-1:0]            cur_id,
  output logic [ADDR_W-1:0]          cur_ep,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       map_load,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       prio_err,
  input  logic                       err_clr,
  input  logic                       mem_fault,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic                       fault_clr,
  output logic                       fault_valid,
  output logic [ADDR_W-1:0]          fault_addr,
  output logic [ID_W-1:0]            fault_id
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, LOAD = 2'd2} state_t;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_SWAP = 2'd3} op_t;

  state_t              state_r, state_nxt_s;
  op_t                 op_r, op_s;
  logic                ovf_s, unf_s, perr_s;
  logic                depth_zero_s, depth_full_s;
  logic [IW-1:0]       push_idx_s, pop_idx_s;

  logic [PRIO_W-1:0]   req_prio_r, cur_prio_r;
  logic [ID_W-1:0]     req_id_r, cur_id_r;
  logic [ADDR_W-1:0]   req_sp_r, cur_ep_r;
  logic [DW-1:0]       depth_r;
  logic                map_load_r, overflow_r, underflow_r, prio_err_r;

  logic [PRIO_W-1:0]   frame_prio_r [DEPTH];
  logic [ID_W-1:0]     frame_id_r   [DEPTH];
  logic [ADDR_W-1:0]   frame_ep_r   [DEPTH];

  assign depth_zero_s = (depth_r == {DW{1'b0}});
  assign depth_full_s = (depth_r == DW'(DEPTH));
  // Slot index for a push is the current depth; a pop reads the slot just below it.
  assign push_idx_s   = depth_r[IW-1:0];
  assign pop_idx_s    = push_idx_s - IW'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request decode and next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    op_s        = OP_NONE;
    ovf_s       = 1'b0;
    unf_s       = 1'b0;
    perr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (take && (!ret || depth_zero_s)) begin
          if (depth_full_s) begin
            ovf_s = 1'b1;
          end else if (!depth_zero_s && (irq_prio <= cur_prio_r)) begin
            perr_s = 1'b1;
          end else begin
            op_s = OP_PUSH;
          end
        end else if (take && ret) begin
          op_s = OP_SWAP;
        end else if (ret) begin
          if (depth_zero_s) begin
            unf_s = 1'b1;
          end else begin
            op_s = OP_POP;
          end
        end else begin
          op_s = OP_NONE;
        end
        if (op_s != OP_NONE) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC:    state_nxt_s = LOAD;
      LOAD:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Context datapath: capture the request on accept, commit it in EXEC, strobe map_load in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= OP_NONE;
      req_prio_r <= {PRIO_W{1'b0}};
      req_id_r   <= {ID_W{1'b0}};
      req_sp_r   <= {ADDR_W{1'b0}};
      cur_prio_r <= {PRIO_W{1'b0}};
      cur_id_r   <= {ID_W{1'b0}};
      cur_ep_r   <= BASE_EP;
      depth_r    <= {DW{1'b0}};
      map_load_r <= 1'b0;
    end else begin
      map_load_r <= (state_r == EXEC);
      case (state_r)
        IDLE: begin
          if (op_s != OP_NONE) begin
            op_r       <= op_s;
            req_prio_r <= irq_prio;
            req_id_r   <= irq_id;
            req_sp_r   <= sp;
          end
        end
        EXEC: begin
          case (op_r)
            OP_PUSH: begin
              cur_prio_r <= req_prio_r;
              cur_id_r   <= req_id_r;
              cur_ep_r   <= req_sp_r;
              depth_r    <= depth_r + DW'(1);
            end
            OP_POP: begin
              cur_prio_r <= frame_prio_r[pop_idx_s];
              cur_id_r   <= frame_id_r[pop_idx_s];
              cur_ep_r   <= frame_ep_r[pop_idx_s];
              depth_r    <= depth_r - DW'(1);
            end
            OP_SWAP: begin
              cur_prio_r <= req_prio_r;
              cur_id_r   <= req_id_r;
              cur_ep_r   <= req_sp_r;
            end
            default: begin
              depth_r <= depth_r;
            end
          endcase
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  // Frame storage; slots at or above depth are never read so they carry no reset
  always_ff @(posedge clk) begin
    if (!reset && (state_r == EXEC) && (op_r == OP_PUSH)) begin
      frame_prio_r[push_idx_s] <= cur_prio_r;
      frame_id_r[push_idx_s]   <= cur_id_r;
      frame_ep_r[push_idx_s]   <= cur_ep_r;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      prio_err_r  <= 1'b0;
    end else begin
      overflow_r  <= (overflow_r  & ~err_clr) | ovf_s;
      underflow_r <= (underflow_r & ~err_clr) | unf_s;
      prio_err_r  <= (prio_err_r  & ~err_clr) | perr_s;
    end
  end

`ifdef MPU_CTX_FAULT_LATCH_EN
  logic              fault_valid_r;
  logic [ADDR_W-1:0] fault_addr_r;
  logic [ID_W-1:0]   fault_id_r;

  // First fault is held until released; a fault arriving with the release is captured fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_r <= 1'b0;
      fault_addr_r  <= {ADDR_W{1'b0}};
      fault_id_r    <= {ID_W{1'b0}};
    end else if (mem_fault && (!fault_valid_r || fault_clr)) begin
      fault_valid_r <= 1'b1;
      fault_addr_r  <= mem_addr;
      fault_id_r    <= cur_id_r;
    end else if (fault_clr) begin
      fault_valid_r <= 1'b0;
    end
  end

  assign fault_valid = fault_valid_r;
  assign fault_addr  = fault_addr_r;
  assign fault_id    = fault_id_r;
`else
  logic fault_inputs_unused_s;
  assign fault_inputs_unused_s = ^{mem_fault, mem_addr, fault_clr};
  assign fault_valid = 1'b0;
  assign fault_addr  = {ADDR_W{1'b0}};
  assign fault_id    = {ID_W{1'b0}};
`endif

  assign ready     = (state_r == IDLE);
  assign cur_prio  = cur_prio_r;
  assign cur_id    = cur_id_r;
  assign cur_ep    = cur_ep_r;
  assign depth     = depth_r;
  assign map_load  = map_load_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign prio_err  = prio_err_r;

endmodule

// File: tb/tb_mpu_ctx_stack.sv
// Directed bench for mpu_ctx_stack: a reference context model feeds a scoreboard that is
// checked on each map_load strobe; honours MPU_CTX_FAULT_LATCH_EN for the fault checks.
module tb_mpu_ctx_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        take = 1'b0, ret = 1'b0;
  logic [7:0]  irq_prio = 8'd0;
  logic [3:0]  irq_id = 4'd0;
  logic [15:0] sp = 16'd0;
  logic        err_clr = 1'b0, mem_fault = 1'b0, fault_clr = 1'b0;
  logic [15:0] mem_addr = 16'd0;
  logic        ready, map_load, overflow, underflow, prio_err, fault_valid;
  logic [7:0]  cur_prio;
  logic [3:0]  cur_id, fault_id;
  logic [15:0] cur_ep, fault_addr;
  logic [3:0]  depth;

`ifdef MPU_CTX_FAULT_LATCH_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  mpu_ctx_stack dut (
    .clk(clk), .reset(reset), .take(take), .ret(ret),
    .irq_prio(irq_prio), .irq_id(irq_id), .sp(sp),
    .ready(ready), .cur_prio(cur_prio), .cur_id(cur_id), .cur_ep(cur_ep),
    .depth(depth), .map_load(map_load),
    .overflow(overflow), .underflow(underflow), .prio_err(prio_err),
    .err_clr(err_clr), .mem_fault(mem_fault), .mem_addr(mem_addr),
    .fault_clr(fault_clr), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_id(fault_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  prio;
    logic [3:0]  id;
    logic [15:0] ep;
    logic [3:0]  dep;
  } exp_t;
  typedef struct packed {
    logic [7:0]  prio;
    logic [3:0]  id;
    logic [15:0] ep;
  } frm_t;

  exp_t        sb[$];
  frm_t        stk[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  m_prio;
  logic [3:0]  m_id;
  logic [15:0] m_ep;
  int          m_depth;
  logic        m_ovf, m_unf, m_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 8'd0; m_id = 4'd0; m_ep = 16'hFFFF; m_depth = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0;
    stk.delete();
    sb.delete();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_prio"}, 32'(cur_prio), 32'(m_prio));
    chk({tag, "_id"}, 32'(cur_id), 32'(m_id));
    chk({tag, "_ep"}, 32'(cur_ep), 32'(m_ep));
    chk({tag, "_depth"}, 32'(depth), 32'(m_depth));
    chk({tag, "_flags"}, 32'({overflow, underflow, prio_err}), 32'({m_ovf, m_unf, m_perr}));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_load"}, 32'(map_load), 32'd0);
    chk({tag, "_fault"}, 32'({fault_valid, fault_addr, fault_id}), 32'd0);
    chk_model(tag);
  endtask

  // Drive one request held for a single accept edge; the model decides accept vs drop.
  task automatic req(input logic t, input logic r, input logic [7:0] p,
                     input logic [3:0] i, input logic [15:0] s);
    bit   acc;
    int   cyc;
    exp_t e;
    frm_t f;
    acc = 1'b0;
    if (t && (!r || m_depth == 0)) begin
      if (m_depth == 8) m_ovf = 1'b1;
      else if (m_depth != 0 && p <= m_prio) m_perr = 1'b1;
      else begin
        stk.push_back({m_prio, m_id, m_ep});
        m_prio = p; m_id = i; m_ep = s; m_depth++; acc = 1'b1;
      end
    end else if (t && r) begin
      m_prio = p; m_id = i; m_ep = s; acc = 1'b1;
    end else if (r) begin
      if (m_depth == 0) m_unf = 1'b1;
      else begin
        f = stk.pop_back();
        m_prio = f.prio; m_id = f.id; m_ep = f.ep; m_depth--; acc = 1'b1;
      end
    end
    if (acc) sb.push_back({m_prio, m_id, m_ep, 4'(m_depth)});
    take = t; ret = r; irq_prio = p; irq_id = i; sp = s;
    @(negedge clk);
    take = 1'b0; ret = 1'b0;
    if (acc) begin
      chk("exec_ready", 32'(ready), 32'd0);
      chk("exec_load", 32'(map_load), 32'd0);
      cyc = 0;
      while (cyc < 4 && !map_load) begin
        @(negedge clk);
        cyc++;
      end
      chk("load_latency", 32'(cyc), 32'd1);
      e = sb.pop_front();
      chk("load_ready", 32'(ready), 32'd0);
      chk("sb_prio", 32'(cur_prio), 32'(e.prio));
      chk("sb_id", 32'(cur_id), 32'(e.id));
      chk("sb_ep", 32'(cur_ep), 32'(e.ep));
      chk("sb_depth", 32'(depth), 32'(e.dep));
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_load", 32'(map_load), 32'd0);
    end else begin
      chk("drop_ready", 32'(ready), 32'd1);
      chk("drop_load", 32'(map_load), 32'd0);
      @(negedge clk);
      chk("drop_load2", 32'(map_load), 32'd0);
    end
    chk_model("req");
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0;
    chk("err_clr", 32'({overflow, underflow, prio_err}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Basic push and explicit context values
    req(1'b1, 1'b0, 8'd3, 4'd2, 16'h0500);
    chk("push1_ctx", 32'({cur_prio, cur_id, cur_ep}), 32'({8'd3, 4'd2, 16'h0500}));
    chk("push1_depth", 32'(depth), 32'd1);

    // Nest then return
    req(1'b1, 1'b0, 8'd5, 4'd4, 16'h0480);
    chk("nest_depth", 32'(depth), 32'd2);
    req(1'b0, 1'b1, 8'd0, 4'd0, 16'h0000);
    chk("pop_ctx", 32'({cur_prio, cur_id, cur_ep, depth}), 32'({8'd3, 4'd2, 16'h0500, 4'd1}));

    // Equal priority is rejected; clear; error concurrent with clear stays set
    req(1'b1, 1'b0, 8'd3, 4'd9, 16'h0111);
    chk("prio_err_set", 32'(prio_err), 32'd1);
    clr_err();
    err_clr = 1'b1; take = 1'b1; irq_prio = 8'd2;
    @(negedge clk);
    err_clr = 1'b0; take = 1'b0;
    m_perr = 1'b1;
    chk("prio_err_vs_clr", 32'(prio_err), 32'd1);
    chk("prio_err_vs_clr_load", 32'(map_load), 32'd0);
    clr_err();

    // Fill to capacity, overflow, drain, underflow
    for (int k = 0; k < 7; k++)
      req(1'b1, 1'b0, 8'(4 + k), 4'(k), 16'h0400 - 16'(k * 16));
    chk("full_depth", 32'(depth), 32'd8);
    req(1'b1, 1'b0, 8'd50, 4'd15, 16'h0100);
    chk("overflow_set", 32'({overflow, depth}), 32'({1'b1, 4'd8}));
    for (int k = 0; k < 8; k++)
      req(1'b0, 1'b1, 8'd0, 4'd0, 16'h0000);
    chk("drained_ctx", 32'({cur_prio, cur_id, cur_ep, depth}), 32'({8'd0, 4'd0, 16'hFFFF, 4'd0}));
    req(1'b0, 1'b1, 8'd0, 4'd0, 16'h0000);
    chk("underflow_set", 32'(underflow), 32'd1);
    clr_err();

    // Tail-chain swap at depth 2, then pop back to the first handler
    req(1'b1, 1'b0, 8'd1, 4'd1, 16'h0700);
    req(1'b1, 1'b0, 8'd2, 4'd3, 16'h0600);
    req(1'b1, 1'b1, 8'd7, 4'd6, 16'h0400);
    chk("swap_ctx", 32'({cur_prio, cur_id, cur_ep, depth}), 32'({8'd7, 4'd6, 16'h0400, 4'd2}));
    req(1'b0, 1'b1, 8'd0, 4'd0, 16'h0000);
    req(1'b0, 1'b1, 8'd0, 4'd0, 16'h0000);
    // take+ret at depth 0 behaves as a push with no priority check
    req(1'b1, 1'b1, 8'd0, 4'd3, 16'h0300);
    chk("swap_d0_depth", 32'(depth), 32'd1);

    // Reset during EXEC: operation abandoned, no strobe afterwards
    take = 1'b1; irq_prio = 8'd9; irq_id = 4'd1; sp = 16'h1000;
    @(negedge clk);
    take = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_vals("rst_exec");
    @(negedge clk);
    chk("rst_exec_noload", 32'(map_load), 32'd0);

    // Reset during LOAD
    take = 1'b1; irq_prio = 8'd9; irq_id = 4'd1; sp = 16'h1000;
    @(negedge clk);
    take = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_vals("rst_load");
    @(negedge clk);
    chk("rst_load_noload", 32'(map_load), 32'd0);

    // Fault capture
    req(1'b1, 1'b0, 8'd4, 4'd5, 16'h0700);
    mem_fault = 1'b1; mem_addr = 16'h0123;
    @(negedge clk);
    mem_addr = 16'h0200;
    @(negedge clk);
    mem_fault = 1'b0;
    chk("fault_first", 32'({fault_valid, fault_addr, fault_id}),
        FLT ? 32'({1'b1, 16'h0123, 4'd5}) : 32'd0);
    fault_clr = 1'b1; mem_fault = 1'b1; mem_addr = 16'h0300;
    @(negedge clk);
    fault_clr = 1'b0; mem_fault = 1'b0;
    chk("fault_reload", 32'({fault_valid, fault_addr}),
        FLT ? 32'({1'b1, 16'h0300}) : 32'd0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_release", 32'(fault_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
